// File: rtl/vx_writeback_pkg.sv
// vx_writeback_pkg
// Shared constants and types for the writeback stage: commit-source
// indices, packet field widths, the packed writeback packet and a small
// modulo-NUM_REQS increment helper used by the round-robin pointer.
package vx_writeback_pkg;

  localparam int NUM_REQS    = 5;
  localparam int NUM_THREADS = 4;
  localparam int NW_BITS     = 2;
  localparam int PC_W        = 32;
  localparam int RD_W        = 5;
  localparam int LANE_W      = NUM_THREADS * 32;
  localparam int PERF_W      = 44;
  localparam int IDX_W       = 3;

  // Commit source indices
  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_LSU = 1;
  localparam int WB_SRC_CSR = 2;
  localparam int WB_SRC_FPU = 3;
  localparam int WB_SRC_GPU = 4;

  typedef struct packed {
    logic [NW_BITS-1:0]     wid;
    logic [PC_W-1:0]        pc;
    logic [NUM_THREADS-1:0] tmask;
    logic [RD_W-1:0]        rd;
    logic                   eop;
    logic [LANE_W-1:0]      data;
  } wb_pkt_t;

  // Source index + 1, wrapping from NUM_REQS-1 back to 0.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQS - 1)) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/vx_writeback_if.sv
// vx_writeback_if
// Bundles the per-source commit request bus and the registered writeback
// bus.
//   master : commit sources side (drives req_*, observes req_ready, wb_*)
//   slave  : writeback stage (consumes req_*, drives req_ready, wb_*, perf)
// Handshake: a source packet transfers in a cycle where req_valid[i] and
// req_ready[i] are both high; req_ready is combinational from the current
// inputs and state. The wb_* bus has no back-pressure: wb_valid marks a
// packet presented for exactly one cycle.
interface vx_writeback_if;
  import vx_writeback_pkg::*;

  logic [NUM_REQS-1:0]             req_valid;
  logic [NUM_REQS-1:0]             req_ready;
  logic [NUM_REQS*NW_BITS-1:0]     req_wid;
  logic [NUM_REQS*PC_W-1:0]        req_PC;
  logic [NUM_REQS*NUM_THREADS-1:0] req_tmask;
  logic [NUM_REQS*RD_W-1:0]        req_rd;
  logic [NUM_REQS-1:0]             req_wb;
  logic [NUM_REQS*LANE_W-1:0]      req_data;
  logic [NUM_REQS-1:0]             req_eop;

  logic                            wb_valid;
  logic [NW_BITS-1:0]              wb_wid;
  logic [PC_W-1:0]                 wb_PC;
  logic [NUM_THREADS-1:0]          wb_tmask;
  logic [RD_W-1:0]                 wb_rd;
  logic [LANE_W-1:0]               wb_data;
  logic                            wb_eop;
  logic [PERF_W-1:0]               perf_wb_stalls;

  modport master (
    output req_valid, req_wid, req_PC, req_tmask, req_rd, req_wb, req_data, req_eop,
    input  req_ready,
    input  wb_valid, wb_wid, wb_PC, wb_tmask, wb_rd, wb_data, wb_eop, perf_wb_stalls
  );

  modport slave (
    input  req_valid, req_wid, req_PC, req_tmask, req_rd, req_wb, req_data, req_eop,
    output req_ready,
    output wb_valid, wb_wid, wb_PC, wb_tmask, wb_rd, wb_data, wb_eop, perf_wb_stalls
  );

endinterface

// File: rtl/vx_writeback_rr_lock_arbiter.sv
// vx_writeback_rr_lock_arbiter
// Round-robin arbiter with an instruction lock. In IDLE the search starts
// at rr_ptr and wraps; in LOCKED only the locked source may be granted.
//   clk, reset        : clock, synchronous active-high reset
//   req_i             : per-source request (already gated by the caller)
//   lock_i            : granted packet is not the last of its instruction
//   unlock_i          : granted packet is the last of its instruction
//   grant_o           : one-hot grant
//   grant_idx_o       : index of the granted source
//   grant_valid_o     : some source granted this cycle
//   dbg_locked_o      : FSM state (1 = LOCKED)
//   dbg_lock_src_o    : source owning the lock
//   dbg_rr_ptr_o      : round-robin search start
module vx_writeback_rr_lock_arbiter
  import vx_writeback_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req_i,
  input  logic                lock_i,
  input  logic                unlock_i,
  output logic [NUM_REQS-1:0] grant_o,
  output logic [IDX_W-1:0]    grant_idx_o,
  output logic                grant_valid_o,
  output logic                dbg_locked_o,
  output logic [IDX_W-1:0]    dbg_lock_src_o,
  output logic [IDX_W-1:0]    dbg_rr_ptr_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] lock_src_q, lock_src_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] scan_idx;

  // Grant selection. Kept separate from next-state logic because lock_i /
  // unlock_i are derived from the granted source by the parent.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    scan_idx  = rr_ptr_q;
    if (state_q == ST_LOCKED) begin
      if (req_i[lock_src_q]) begin
        gnt_valid = 1'b1;
        gnt_idx   = lock_src_q;
      end
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (!gnt_valid && req_i[scan_idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = scan_idx;
        end
        scan_idx = wrap_inc(scan_idx);
      end
    end
  end

  always_comb begin
    grant_o = '0;
    if (gnt_valid) grant_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    lock_src_d = lock_src_q;
    rr_ptr_d   = rr_ptr_q;
    if (gnt_valid) begin
      if (unlock_i) begin
        state_d  = ST_IDLE;
        rr_ptr_d = wrap_inc(gnt_idx);
      end else if (lock_i) begin
        state_d    = ST_LOCKED;
        lock_src_d = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lock_src_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_src_q <= lock_src_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign grant_idx_o    = gnt_idx;
  assign grant_valid_o  = gnt_valid;
  assign dbg_locked_o   = (state_q == ST_LOCKED);
  assign dbg_lock_src_o = lock_src_q;
  assign dbg_rr_ptr_o   = rr_ptr_q;

endmodule

// File: rtl/vx_writeback.sv
// vx_writeback
// Commit-to-writeback stage: arbitrates up to NUM_REQS commit sources onto
// one registered writeback bus, one writing packet per cycle. Non-writing
// packets (wb=0) are acknowledged immediately and bypass arbitration.
//   clk, reset      : clock, synchronous active-high reset
//   bus (slave)     : req_* commit bus in, req_ready out, wb_* out,
//                     perf_wb_stalls out
//   dbg_locked_o    : arbiter FSM state (1 = LOCKED)
//   dbg_lock_src_o  : source owning the lock
//   dbg_rr_ptr_o    : round-robin pointer
module vx_writeback
  import vx_writeback_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  vx_writeback_if.slave    bus,
  output logic             dbg_locked_o,
  output logic [IDX_W-1:0] dbg_lock_src_o,
  output logic [IDX_W-1:0] dbg_rr_ptr_o
);

  logic [NUM_REQS-1:0] wr_req;
  logic [NUM_REQS-1:0] grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_valid;
  wb_pkt_t             sel_pkt;
  logic                stall;

  logic                wb_valid_q;
  wb_pkt_t             wb_pkt_q;
  logic [PERF_W-1:0]   perf_q, perf_d;

  // Only writing packets compete; nothing is granted while in reset.
  assign wr_req = bus.req_valid & bus.req_wb & {NUM_REQS{~reset}};

  vx_writeback_rr_lock_arbiter u_arb (
    .clk            (clk),
    .reset          (reset),
    .req_i          (wr_req),
    .lock_i         (~sel_pkt.eop),
    .unlock_i       (sel_pkt.eop),
    .grant_o        (grant),
    .grant_idx_o    (grant_idx),
    .grant_valid_o  (grant_valid),
    .dbg_locked_o   (dbg_locked_o),
    .dbg_lock_src_o (dbg_lock_src_o),
    .dbg_rr_ptr_o   (dbg_rr_ptr_o)
  );

  // Mux the granted source's fields out of the flattened request bus.
  always_comb begin
    sel_pkt = '0;
    for (int s = 0; s < NUM_REQS; s++) begin
      if (grant_idx == IDX_W'(s)) begin
        sel_pkt.wid   = bus.req_wid[s*NW_BITS +: NW_BITS];
        sel_pkt.pc    = bus.req_PC[s*PC_W +: PC_W];
        sel_pkt.tmask = bus.req_tmask[s*NUM_THREADS +: NUM_THREADS];
        sel_pkt.rd    = bus.req_rd[s*RD_W +: RD_W];
        sel_pkt.eop   = bus.req_eop[s];
        sel_pkt.data  = bus.req_data[s*LANE_W +: LANE_W];
      end
    end
  end

  // Non-writing packets are always accepted, except during reset.
  assign bus.req_ready = reset ? '0 : (grant | (bus.req_valid & ~bus.req_wb));

  assign stall  = |(wr_req & ~grant);
  assign perf_d = perf_q + {{(PERF_W-1){1'b0}}, stall};

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_pkt_q   <= '0;
      perf_q     <= '0;
    end else begin
      wb_valid_q <= grant_valid;
      perf_q     <= perf_d;
      // Data fields only load on a grant so they hold while wb_valid=0.
      if (grant_valid) wb_pkt_q <= sel_pkt;
    end
  end

  assign bus.wb_valid       = wb_valid_q;
  assign bus.wb_wid         = wb_pkt_q.wid;
  assign bus.wb_PC          = wb_pkt_q.pc;
  assign bus.wb_tmask       = wb_pkt_q.tmask;
  assign bus.wb_rd          = wb_pkt_q.rd;
  assign bus.wb_data        = wb_pkt_q.data;
  assign bus.wb_eop         = wb_pkt_q.eop;
  assign bus.perf_wb_stalls = perf_q;

endmodule

// File: tb/tb_vx_writeback.sv
module tb_vx_writeback;
  import vx_writeback_pkg::*;

  localparam int PKT_W = $bits(wb_pkt_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_writeback_if bus();
  logic             dbg_locked;
  logic [IDX_W-1:0] dbg_lock_src;
  logic [IDX_W-1:0] dbg_rr_ptr;

  vx_writeback dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .dbg_locked_o   (dbg_locked),
    .dbg_lock_src_o (dbg_lock_src),
    .dbg_rr_ptr_o   (dbg_rr_ptr)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [4:0] valid;
    logic [4:0] wb;
    logic [4:0] eop;
    logic [4:0] exp_ready;
    int         exp_perf;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  // ---------------- scoreboard ----------------
  logic [PKT_W-1:0] exp_q[$];
  wb_pkt_t          pkt [NUM_REQS];
  wb_pkt_t          last_pkt;
  int               checks;
  int               failures;

  task automatic check(input string name, input logic [PKT_W-1:0] act,
                       input logic [PKT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic wb_pkt_t new_pkt();
    wb_pkt_t p;
    p.wid   = NW_BITS'($urandom_range(0, 3));
    p.pc    = $urandom;
    p.tmask = NUM_THREADS'($urandom_range(1, 15));
    p.rd    = RD_W'($urandom_range(0, 31));
    p.eop   = 1'b0;
    p.data  = {$urandom, $urandom, $urandom, $urandom};
    return p;
  endfunction

  // ---------------- driver: one cycle ----------------
  task automatic apply(input logic rst, input logic [4:0] valid,
                       input logic [4:0] wb, input logic [4:0] eop,
                       input logic [4:0] exp_ready, input int exp_perf);
    wb_pkt_t act;
    logic [PKT_W-1:0] exp;
    @(negedge clk);
    reset         = rst;
    bus.req_valid = valid;
    bus.req_wb    = wb;
    bus.req_eop   = eop;
    for (int s = 0; s < NUM_REQS; s++) begin
      pkt[s].eop = eop[s];
      bus.req_wid[s*NW_BITS +: NW_BITS]           = pkt[s].wid;
      bus.req_PC[s*PC_W +: PC_W]                  = pkt[s].pc;
      bus.req_tmask[s*NUM_THREADS +: NUM_THREADS] = pkt[s].tmask;
      bus.req_rd[s*RD_W +: RD_W]                  = pkt[s].rd;
      bus.req_data[s*LANE_W +: LANE_W]            = pkt[s].data;
    end
    #1;
    check("req_ready", PKT_W'(bus.req_ready), PKT_W'(exp_ready));
    for (int s = 0; s < NUM_REQS; s++) begin
      if (!rst && exp_ready[s] && valid[s]) begin
        if (wb[s]) exp_q.push_back(pkt[s]);
        pkt[s] = new_pkt();
      end
    end
    @(posedge clk);
    #1;
    act.wid   = bus.wb_wid;
    act.pc    = bus.wb_PC;
    act.tmask = bus.wb_tmask;
    act.rd    = bus.wb_rd;
    act.eop   = bus.wb_eop;
    act.data  = bus.wb_data;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check("wb_valid_hi", PKT_W'(bus.wb_valid), PKT_W'(1));
      check("wb_packet", act, exp);
      last_pkt = exp;
    end else begin
      check("wb_valid_lo", PKT_W'(bus.wb_valid), PKT_W'(0));
      if (rst) last_pkt = '0;
      check("wb_hold", act, last_pkt);
    end
    check("perf_wb_stalls", PKT_W'(bus.perf_wb_stalls), PKT_W'(exp_perf));
  endtask

  // ---------------- test ----------------
  initial begin
    checks   = 0;
    failures = 0;
    last_pkt = '0;
    reset    = 1'b1;
    bus.req_valid = '0;
    bus.req_wb    = '0;
    bus.req_eop   = '0;
    bus.req_wid   = '0;
    bus.req_PC    = '0;
    bus.req_tmask = '0;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    for (int s = 0; s < NUM_REQS; s++) pkt[s] = new_pkt();

    //            rst   valid     wb        eop       ready     perf
    // all five sources, eop=1, grants 0..4 in order
    vecs[0]  = '{1'b1, 5'b11111, 5'b11111, 5'b11111, 5'b00000, 0};
    vecs[1]  = '{1'b0, 5'b11111, 5'b11111, 5'b11111, 5'b00001, 1};
    vecs[2]  = '{1'b0, 5'b11110, 5'b11110, 5'b11110, 5'b00010, 2};
    vecs[3]  = '{1'b0, 5'b11100, 5'b11100, 5'b11100, 5'b00100, 3};
    vecs[4]  = '{1'b0, 5'b11000, 5'b11000, 5'b11000, 5'b01000, 4};
    vecs[5]  = '{1'b0, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 4};
    vecs[6]  = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 4};
    // after source 4, wrap-around: source 0 before source 4
    vecs[7]  = '{1'b0, 5'b10001, 5'b10001, 5'b10001, 5'b00001, 5};
    vecs[8]  = '{1'b0, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5};
    // non-writing packet on source 2: accepted, no output, pointer kept at 0
    vecs[9]  = '{1'b0, 5'b00100, 5'b00000, 5'b00000, 5'b00100, 5};
    vecs[10] = '{1'b0, 5'b00101, 5'b00101, 5'b00101, 5'b00001, 6};
    vecs[11] = '{1'b0, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 6};
    // pointer to 1, then source 1 sends eop=0,0,1 while source 0 waits
    vecs[12] = '{1'b0, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 6};
    vecs[13] = '{1'b0, 5'b00011, 5'b00011, 5'b00001, 5'b00010, 7};
    vecs[14] = '{1'b0, 5'b00011, 5'b00011, 5'b00001, 5'b00010, 8};
    vecs[15] = '{1'b0, 5'b00011, 5'b00011, 5'b00011, 5'b00010, 9};
    vecs[16] = '{1'b0, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 9};
    // source 3 locks, idles 2 cycles; source 4 blocked; wb=0 still passes
    vecs[17] = '{1'b0, 5'b01000, 5'b01000, 5'b00000, 5'b01000, 9};
    vecs[18] = '{1'b0, 5'b10000, 5'b10000, 5'b10000, 5'b00000, 10};
    vecs[19] = '{1'b0, 5'b10100, 5'b10000, 5'b10000, 5'b00100, 11};
    vecs[20] = '{1'b0, 5'b11000, 5'b11000, 5'b11000, 5'b01000, 12};
    vecs[21] = '{1'b0, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 12};
    // lock on source 1, reset drops it, source 0 wins afterwards
    vecs[22] = '{1'b0, 5'b00010, 5'b00010, 5'b00000, 5'b00010, 12};
    vecs[23] = '{1'b1, 5'b00011, 5'b00011, 5'b00011, 5'b00000, 0};
    vecs[24] = '{1'b0, 5'b00011, 5'b00011, 5'b00011, 5'b00001, 1};
    vecs[25] = '{1'b0, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 1};
    vecs[26] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1};

    for (int v = 0; v < NV; v++)
      apply(vecs[v].rst, vecs[v].valid, vecs[v].wb, vecs[v].eop,
            vecs[v].exp_ready, vecs[v].exp_perf);

    // one writing source every cycle: back-to-back throughput
    for (int i = 0; i < 6; i++)
      apply(1'b0, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 1);

    // two sources held continuously: strict alternation 0,1,0,1
    // (pointer is 3 after the source-2 burst, so the search reaches 0 first)
    for (int i = 0; i < 4; i++)
      apply(1'b0, 5'b00011, 5'b00011, 5'b00011,
            (i % 2 == 0) ? 5'b00001 : 5'b00010, 2 + i);

    // idle tail: output must drop and hold the last packet
    apply(1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5);

    check("scoreboard_empty", PKT_W'(exp_q.size()), PKT_W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vx_writeback.md
VX_WRITEBACK -- requirements
Module: VX_writeback

Interface
REQ-001 Parameter NUM_REQS, 5, number of commit sources (0=ALU, 1=LSU, 2=CSR, 3=FPU, 4=GPU).
REQ-002 Parameter NUM_THREADS, 4, lanes per packet.
REQ-003 Parameter NW_BITS, 2, warp-id width.
REQ-004 Port clk, input, 1, clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port req_valid, input, NUM_REQS, per-source commit packet valid.
REQ-007 Port req_ready, output, NUM_REQS, per-source packet accepted this cycle.
REQ-008 Port req_wid, input, NUM_REQS*NW_BITS, per-source warp id.
REQ-009 Port req_PC, input, NUM_REQS*32, per-source instruction PC.
REQ-010 Port req_tmask, input, NUM_REQS*NUM_THREADS, per-source thread mask.
REQ-011 Port req_rd, input, NUM_REQS*5, per-source destination register.
REQ-012 Port req_wb, input, NUM_REQS, packet writes the register file.
REQ-013 Port req_data, input, NUM_REQS*NUM_THREADS*32, per-source lane results.
REQ-014 Port req_eop, input, NUM_REQS, last packet of the instruction.
REQ-015 Ports wb_valid/wb_wid/wb_PC/wb_tmask/wb_rd/wb_data/wb_eop, output, 1/NW_BITS/32/NUM_THREADS/5/NUM_THREADS*32/1, registered writeback to GPR and scoreboard; no back-pressure.
REQ-016 Port perf_wb_stalls, output, 44, count of cycles with a waiting writing packet not granted.

Function
REQ-017 A packet with valid=1, wb=0 SHALL get req_ready=1 in the same cycle, never appear on wb_*, and not affect arbitration state.
REQ-018 At most one packet with valid=1, wb=1 SHALL be granted per cycle; req_ready is combinational and high only for the granted source.
REQ-019 Grant SHALL be round-robin: search starts at rr_ptr, wraps from NUM_REQS-1 to 0.
REQ-020 On a granted packet with eop=1, rr_ptr SHALL become (granted index + 1) mod NUM_REQS.
REQ-021 On a granted packet with eop=0, the block SHALL enter LOCKED on that source; only it may be granted until its eop=1 packet is granted, even if it idles; other sources wait.
REQ-022 The states are IDLE (unlocked) and LOCKED(src); IDLE->LOCKED on eop=0 grant, LOCKED->IDLE on eop=1 grant by src.
REQ-023 A granted packet SHALL appear on wb_* exactly one cycle after grant with all fields unchanged; wb_valid=0 in cycles following no grant.
REQ-024 When wb_valid=0 the wb_* data fields SHALL hold their last values.
REQ-025 Sustained throughput SHALL be one writing packet per cycle.
REQ-026 perf_wb_stalls SHALL increment by 1 in each cycle where some source has valid=1, wb=1, ready=0; saturation is not required.

Reset
REQ-027 On reset: wb_valid=0, wb_wid/wb_PC/wb_tmask/wb_rd/wb_data/wb_eop=0, rr_ptr=0, state IDLE, perf_wb_stalls=0.
REQ-028 While reset=1, req_ready SHALL be 0 for all sources.
REQ-029 Reset asserted while LOCKED SHALL drop the lock; the packet in the output register is discarded.

Structure
REQ-030 Source index constants (WB_SRC_ALU..WB_SRC_GPU) and the packet field widths SHALL live in the shared VX_gpu_pkg package.
REQ-031 Arbitration SHALL be one sub-module, VX_rr_lock_arbiter (inputs requests, lock, unlock; outputs one-hot grant and index).
REQ-032 The output register SHALL be the only datapath storage; no FIFO.

Verification
REQ-033 Sources 0-4 all valid, wb=1, eop=1 in the first cycle after reset, held until accepted -> grants 0,1,2,3,4 on consecutive cycles; wb_valid high for 5 cycles starting 1 cycle later.
REQ-034 Source 2 valid, wb=0 alone -> req_ready[2]=1 same cycle; wb_valid stays 0; rr_ptr unchanged.
REQ-035 Source 1 sends 3 packets (eop=0,0,1) while source 0 is valid -> output order src1,src1,src1,src0; perf_wb_stalls increases by 3.
REQ-036 Source 3 locked (eop=0 granted), idles 2 cycles, source 4 valid -> source 4 not granted until source 3's eop=1 packet is granted.
REQ-037 Reset pulsed while locked on source 1 -> next cycle wb_valid=0, perf_wb_stalls=0; source 0 then granted first.
REQ-038 Source 4 granted with eop=1, then sources 0 and 4 valid -> source 0 granted first (wrap-around).
